// File: rtl/run_controller_pkg.sv
// Shared types, widths and helpers for the run controller.
package run_controller_pkg;

   typedef enum logic [2:0] {IDLE, RST, REQ, RUN, DUMP} run_state_t;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/run_controller_if.sv
// Core request/done, data-memory read port and result stream seen by the run controller.
interface run_controller_if #(
   parameter int unsigned PROG_W = 2
);
   import run_controller_pkg::*;

   logic [PROG_W-1:0] core_prog;
   logic              core_reset;
   logic              core_req;
   logic              core_done;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_last;

   modport master (
      output core_prog, core_reset, core_req, mem_rd_addr, res_valid, res_data, res_last,
      input  core_done, mem_rd_data, res_ready
   );

   modport slave (
      input  core_prog, core_reset, core_req, mem_rd_addr, res_valid, res_data, res_last,
      output core_done, mem_rd_data, res_ready
   );

endinterface

// File: rtl/run_controller_timer.sv
// Saturating cycle counter with clear/enable; hit_o flags count == term_i.
module run_controller_timer
   import run_controller_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             hit_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign hit_o = (count_q == term_i);

endmodule

// File: rtl/run_controller.sv
// Host-side run sequencer: resets and starts the core, times the run, then streams a
// window of data memory out over a valid/ready port.
module run_controller
   import run_controller_pkg::*;
#(
   parameter int unsigned       PROG_W       = 2,
   parameter int unsigned       CORE_RST_CYC = 2,
   parameter int unsigned       TIMEOUT_CYC  = 4096,
   parameter logic [ADDR_W-1:0] DUMP_BASE    = 8'h00,
   parameter int unsigned       DUMP_LEN     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PROG_W-1:0] prog_sel,
   run_controller_if.master  bus,
   output logic              busy,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam logic [CNT_W-1:0]  RstTerm = CNT_W'(CORE_RST_CYC - 1);
   localparam logic [CNT_W-1:0]  RunTerm = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DUMP_LEN - 1);

   run_state_t        state_q, state_d;
   logic [PROG_W-1:0] core_prog_q, core_prog_d;
   logic              core_reset_q, core_reset_d;
   logic              core_req_q, core_req_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              res_valid_q, res_valid_d;
   logic              res_last_q, res_last_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

   logic              tmr_clr, tmr_en, tmr_hit;
   logic [CNT_W-1:0]  tmr_term;

   // One timer serves both the core-reset hold and the run timeout.
   run_controller_timer u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .term_i (tmr_term),
      .hit_o  (tmr_hit)
   );

   always_comb begin
      state_d       = state_q;
      core_prog_d   = core_prog_q;
      rd_addr_d     = rd_addr_q;
      idx_d         = idx_q;
      res_valid_d   = res_valid_q;
      res_last_d    = res_last_q;
      timeout_d     = timeout_q;
      cycle_count_d = cycle_count_q;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;
      tmr_term      = RstTerm;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               core_prog_d   = prog_sel;
               timeout_d     = 1'b0;
               cycle_count_d = '0;
               tmr_clr       = 1'b1;
               state_d       = RST;
            end
         end
         RST: begin
            tmr_en = 1'b1;
            if (tmr_hit) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // core_done may still be high from the previous run; it is not looked at here.
            tmr_clr = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            tmr_en        = 1'b1;
            tmr_term      = RunTerm;
            cycle_count_d = sat_inc(cycle_count_q);
            if (bus.core_done) begin
               idx_d       = '0;
               rd_addr_d   = DUMP_BASE;
               res_valid_d = 1'b1;
               res_last_d  = (LastIdx == '0);
               state_d     = DUMP;
            end else if (tmr_hit) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DUMP: begin
            if (res_valid_q && bus.res_ready) begin
               if (res_last_q) begin
                  idx_d       = '0;
                  rd_addr_d   = DUMP_BASE;
                  res_valid_d = 1'b0;
                  res_last_d  = 1'b0;
                  state_d     = IDLE;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  rd_addr_d  = DUMP_BASE + idx_d;
                  res_last_d = (idx_d == LastIdx);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      core_reset_d = (state_d == IDLE) || (state_d == RST);
      core_req_d   = (state_d == REQ);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         core_prog_q   <= '0;
         core_reset_q  <= 1'b1;
         core_req_q    <= 1'b0;
         rd_addr_q     <= DUMP_BASE;
         idx_q         <= '0;
         res_valid_q   <= 1'b0;
         res_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         core_prog_q   <= core_prog_d;
         core_reset_q  <= core_reset_d;
         core_req_q    <= core_req_d;
         rd_addr_q     <= rd_addr_d;
         idx_q         <= idx_d;
         res_valid_q   <= res_valid_d;
         res_last_q    <= res_last_d;
         busy_q        <= busy_d;
         timeout_q     <= timeout_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign bus.core_prog   = core_prog_q;
   assign bus.core_reset  = core_reset_q;
   assign bus.core_req    = core_req_q;
   assign bus.mem_rd_addr = rd_addr_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_last    = res_last_q;
   assign bus.res_data    = bus.mem_rd_data;
   assign busy            = busy_q;
   assign timeout         = timeout_q;
   assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: table-driven and randomized runs against a run-level model,
// with a second instance (dump window wrapping past 8'hFF) checked in lockstep.
module tb_run_controller;
   import run_controller_pkg::*;

   localparam int unsigned PROG_W  = 2;
   localparam int unsigned RST_CYC = 2;
   localparam int unsigned TMO     = 20;
   localparam int unsigned LEN     = 4;
   localparam logic [7:0]  BASE_A  = 8'h00;
   localparam logic [7:0]  BASE_B  = 8'hFE;

   typedef struct {
      logic [1:0] prog;
      int         done_at;     // RUN cycle carrying core_done, 0 = never
      int         ready_mode;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
      bit         hold_start;
      bit         mid_start;
   } run_vec_t;

   logic        clk = 1'b0;
   logic        reset, start, done, ready;
   logic [1:0]  prog_sel;
   logic        busy_a, timeout_a, busy_b, timeout_b;
   logic [15:0] cc_a, cc_b;
   logic [7:0]  mem [256];
   int          nvec = 0;
   int          nmis = 0;
   int          idx_b = 0;
   run_vec_t    tbl [9];

   run_controller_if #(.PROG_W(PROG_W)) bus_a ();
   run_controller_if #(.PROG_W(PROG_W)) bus_b ();

   run_controller #(
      .PROG_W(PROG_W), .CORE_RST_CYC(RST_CYC), .TIMEOUT_CYC(TMO), .DUMP_BASE(BASE_A),
      .DUMP_LEN(LEN)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .bus(bus_a.master),
      .busy(busy_a), .timeout(timeout_a), .cycle_count(cc_a)
   );

   run_controller #(
      .PROG_W(PROG_W), .CORE_RST_CYC(RST_CYC), .TIMEOUT_CYC(TMO), .DUMP_BASE(BASE_B),
      .DUMP_LEN(LEN)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .bus(bus_b.master),
      .busy(busy_b), .timeout(timeout_b), .cycle_count(cc_b)
   );

   always #5 clk = ~clk;

   assign bus_a.mem_rd_data = mem[bus_a.mem_rd_addr];
   assign bus_b.mem_rd_data = mem[bus_b.mem_rd_addr];
   assign bus_a.core_done   = done;
   assign bus_b.core_done   = done;
   assign bus_a.res_ready   = ready;
   assign bus_b.res_ready   = ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfers of the wrapping instance: address walks FE,FF,00,01,...
   always @(negedge clk) begin
      logic [7:0] ea;
      if (reset) begin
         idx_b = 0;
      end else if (bus_b.res_valid && bus_b.res_ready) begin
         ea = BASE_B + 8'(idx_b);
         chk("b_addr", bus_b.mem_rd_addr, ea);
         chk("b_data", bus_b.res_data, mem[ea]);
         chk("b_last", bus_b.res_last, (idx_b == LEN - 1));
         idx_b = (idx_b == LEN - 1) ? 0 : idx_b + 1;
      end
   end

   task automatic chk_reset_vals();
      chk("rv_busy", busy_a, 0);
      chk("rv_core_reset", bus_a.core_reset, 1);
      chk("rv_core_req", bus_a.core_req, 0);
      chk("rv_valid", bus_a.res_valid, 0);
      chk("rv_last", bus_a.res_last, 0);
      chk("rv_timeout", timeout_a, 0);
      chk("rv_count", cc_a, 0);
      chk("rv_prog", bus_a.core_prog, 0);
      chk("rv_addr", bus_a.mem_rd_addr, BASE_A);
      chk("rv_addr_b", bus_b.mem_rd_addr, BASE_B);
      chk("rv_core_reset_b", bus_b.core_reset, 1);
   endtask

   task automatic do_run(input run_vec_t v);
      bit         exp_to, seen_valid;
      int         exp_cnt, lat, nrst, nw, cyc;
      logic [7:0] ea;
      logic [3:0] pat;
      pat     = 4'b1001;
      exp_to  = (v.done_at == 0) || (v.done_at > int'(TMO));
      exp_cnt = exp_to ? int'(TMO) : v.done_at;

      prog_sel = v.prog;
      start    = 1'b1;
      if (v.done_at == 1) done = 1'b1;  // stale-looking done already high before REQ
      tick();
      if (!v.hold_start) start = 1'b0;
      prog_sel = ~v.prog;
      chk("rst_busy", busy_a, 1);
      chk("core_prog", bus_a.core_prog, v.prog);
      chk("b_prog", bus_b.core_prog, v.prog);
      chk("start_clears_timeout", timeout_a, 0);
      chk("start_clears_count", cc_a, 0);

      lat  = 1;
      nrst = 0;
      while (!bus_a.core_req && lat < 10) begin
         if (bus_a.core_reset) nrst++;
         tick();
         lat++;
      end
      chk("req_latency", lat, RST_CYC + 1);
      chk("core_reset_cycles", nrst, RST_CYC);
      chk("req_core_reset_low", bus_a.core_reset, 0);
      chk("b_req", bus_b.core_req, 1);

      seen_valid = 1'b0;
      tick();
      chk("req_one_cycle", bus_a.core_req, 0);
      for (int j = 1; j <= int'(TMO); j++) begin
         if (j == v.done_at) done = 1'b1;
         if (v.mid_start && j == 2) start = 1'b1;
         if (v.hold_start && exp_to && j == int'(TMO)) start = 1'b0;
         if (bus_a.res_valid) seen_valid = 1'b1;
         tick();
         if (v.mid_start && j == 2) start = 1'b0;
         if (j == v.done_at) break;
      end
      done = 1'b0;

      if (exp_to) begin
         chk("to_flag", timeout_a, 1);
         chk("to_idle", busy_a, 0);
         chk("to_count", cc_a, exp_cnt);
         chk("to_no_valid", seen_valid | bus_a.res_valid, 0);
      end else begin
         nw  = 0;
         cyc = 0;
         while (nw < int'(LEN) && cyc < 100) begin
            ea = BASE_A + 8'(nw);
            chk("dump_valid", bus_a.res_valid, 1);
            chk("dump_addr", bus_a.mem_rd_addr, ea);
            chk("dump_data", bus_a.res_data, mem[ea]);
            chk("dump_last", bus_a.res_last, (nw == LEN - 1));
            if (!bus_a.res_valid) break;
            case (v.ready_mode)
               0:       ready = 1'b1;
               1:       ready = pat[2'(cyc)];
               default: ready = 1'($urandom_range(0, 1));
            endcase
            if (ready) begin
               nw++;
               if (nw == int'(LEN)) start = 1'b0;
            end
            tick();
            cyc++;
         end
         ready = 1'b0;
         chk("dump_words", nw, LEN);
         chk("end_valid", bus_a.res_valid, 0);
         chk("end_last", bus_a.res_last, 0);
         chk("end_busy", busy_a, 0);
         chk("end_count", cc_a, exp_cnt);
         chk("end_timeout", timeout_a, 0);
      end
      start = 1'b0;
      chk("b_busy", busy_b, 0);
      chk("b_timeout", timeout_b, exp_to);
      chk("b_count", cc_b, exp_cnt);

      tick();
      tick();
      chk("stay_idle", busy_a, 0);
      chk("hold_count", cc_a, exp_cnt);
      chk("hold_timeout", timeout_a, exp_to);
   endtask

   task automatic reset_mid(input bit in_dump);
      prog_sel = 2'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (RST_CYC + 4) tick();
      chk("pre_rst_busy", busy_a, 1);
      chk("pre_rst_count", cc_a, 3);
      if (in_dump) begin
         done = 1'b1;
         tick();
         done  = 1'b0;
         ready = 1'b0;
         tick();
         tick();
         chk("pre_rst_stall_valid", bus_a.res_valid, 1);
      end
      #2 reset = 1'b1;
      #1 chk_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   initial begin
      run_vec_t rv;
      reset    = 1'b0;
      start    = 1'b0;
      done     = 1'b0;
      ready    = 1'b0;
      prog_sel = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      #2 reset = 1'b1;
      #1 chk_reset_vals();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk_reset_vals();

      tbl[0] = '{2'd2, 10, 0, 1'b0, 1'b0};
      tbl[1] = '{2'd1, 0,  0, 1'b0, 1'b0};
      tbl[2] = '{2'd3, 5,  0, 1'b0, 1'b0};
      tbl[3] = '{2'd0, 7,  1, 1'b0, 1'b0};
      tbl[4] = '{2'd2, 3,  0, 1'b1, 1'b0};
      tbl[5] = '{2'd1, 12, 2, 1'b0, 1'b1};
      tbl[6] = '{2'd3, 20, 0, 1'b0, 1'b0};
      tbl[7] = '{2'd0, 1,  1, 1'b0, 1'b0};
      tbl[8] = '{2'd2, 21, 0, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) do_run(tbl[i]);

      reset_mid(1'b0);
      do_run(tbl[0]);
      reset_mid(1'b1);
      do_run(tbl[3]);

      for (int i = 0; i < 12; i++) begin
         rv.prog       = 2'($urandom_range(0, 3));
         rv.done_at    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TMO + 3));
         rv.ready_mode = int'($urandom_range(0, 2));
         rv.hold_start = 1'($urandom_range(0, 1));
         rv.mid_start  = !rv.hold_start && ($urandom_range(0, 1) == 1);
         mem[$urandom_range(0, 255)] = 8'($urandom);
         do_run(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
